ddr4_axi_fifo_rd_stage: RTL



---
 rtl/ddr4_axi_fifo_pkg.sv | 9 +
 rtl/ddr4_axi_sat_cnt.sv | 20 ++
 rtl/ddr4_axi_fifo_rd_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/ddr4_axi_fifo_pkg.sv
// Shared definitions for the DDR4 AXI FIFO reader stage: stage-count encodings and default widths.
package ddr4_axi_fifo_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int C_WIDTH_DEF     = 8;
  localparam int C_CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/ddr4_axi_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ddr4_axi_sat_cnt #(
  parameter int C_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [C_WIDTH-1:0] o_cnt
);
  logic [C_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_cnt <= '0;
    else if (i_clr)                    r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))   r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/ddr4_axi_fifo_rd_stage.sv
// Two-entry registered reader stage (output register + skid) draining a sync FIFO onto a valid/ready stream.
// Optional stall counter enabled by DDR4_AXI_FIFO_RD_STAGE_STALL_CNT_EN.
module ddr4_axi_fifo_rd_stage
  import ddr4_axi_fifo_pkg::*;
#(
  parameter int C_WIDTH     = C_WIDTH_DEF,
  parameter int C_CNT_WIDTH = C_CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [C_WIDTH-1:0]     fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [C_WIDTH-1:0]     m_data,
  output logic [1:0]             stage_cnt,
  output logic [C_CNT_WIDTH-1:0] stall_cnt
);
  logic [1:0]         r_cnt, w_cnt_nxt;
  logic               r_valid;
  logic [C_WIDTH-1:0] r_data, w_data_nxt;
  logic [C_WIDTH-1:0] r_skid, w_skid_nxt;
  logic               w_pop, w_hs;

  // Pop depends only on registered occupancy and FIFO status, never on m_ready.
  assign w_pop = !fifo_empty && (r_cnt != ST_TWO) && !flush && !rst;
  assign w_hs  = r_valid && m_ready;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_data_nxt = r_data;
    w_skid_nxt = r_skid;
    if (flush) begin
      w_cnt_nxt = ST_EMPTY;
    end else begin
      case (r_cnt)
        ST_EMPTY: if (w_pop) begin
          w_data_nxt = fifo_dout;
          w_cnt_nxt  = ST_ONE;
        end
        ST_ONE: begin
          if (w_pop && w_hs) begin
            w_data_nxt = fifo_dout;
          end else if (w_pop) begin
            w_skid_nxt = fifo_dout;
            w_cnt_nxt  = ST_TWO;
          end else if (w_hs) begin
            w_cnt_nxt  = ST_EMPTY;
          end
        end
        ST_TWO: if (w_hs) begin
          w_data_nxt = r_skid;
          w_cnt_nxt  = ST_ONE;
        end
        default: w_cnt_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= ST_EMPTY;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_skid  <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != ST_EMPTY);
      r_data  <= w_data_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  assign fifo_rd_en = w_pop;
  assign m_valid    = r_valid;
  assign m_data     = r_data;
  assign stage_cnt  = r_cnt;

`ifdef DDR4_AXI_FIFO_RD_STAGE_STALL_CNT_EN
  logic [C_CNT_WIDTH-1:0] w_stall;
  ddr4_axi_sat_cnt #(.C_WIDTH(C_CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush),
    .i_inc (r_valid && !m_ready),
    .o_cnt (w_stall)
  );
  assign stall_cnt = w_stall;
`else
  assign stall_cnt = '0;
`endif
endmodule
